// File: rtl/updown_count_pkg.sv
// updown_count_pkg: shared constants and load clamp helper for updown_count_mod
package updown_count_pkg;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam int DEFAULT_WIDTH = 4;

    function automatic logic [31:0] clamp_load(input logic [31:0] r, input logic [31:0] max_count);
        return (r > max_count) ? max_count : r;
    endfunction
endpackage

// File: rtl/count_limit_cmp.sv
// count_limit_cmp: flags when the count sits at MAX_COUNT or at zero
module count_limit_cmp #(
    parameter int          WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 2**WIDTH-1
) (
    input  logic [WIDTH-1:0] q_i,
    output logic             at_max_o,
    output logic             at_zero_o
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

    assign at_max_o  = q_i == MAX_Q;
    assign at_zero_o = q_i == '0;
endmodule

// File: rtl/updown_count_mod.sv
// updown_count_mod: loadable modulo up/down counter with terminal count; UPDOWN_COUNT_OVF_EN adds a sticky wrap flag
module updown_count_mod
    import updown_count_pkg::*;
#(
    parameter int          WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned MAX_COUNT = 2**WIDTH-1
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] R,
    input  logic             L,
    input  logic             E,
    input  logic             Up,
    output logic [WIDTH-1:0] Q,
    output logic             TC
`ifdef UPDOWN_COUNT_OVF_EN
    ,
    input  logic             OvfClr,
    output logic             Ovf
`endif
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] q_q, q_d, load_val;
    logic             at_max, at_zero, wrap;

    count_limit_cmp #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT)) u_cmp (
        .q_i      (q_q),
        .at_max_o (at_max),
        .at_zero_o(at_zero)
    );

    assign load_val = WIDTH'(clamp_load(32'(R), 32'(MAX_COUNT)));
    // wrap marks the edge on which the count rolls over; it is also the cascade enable
    assign wrap = E & ~L & ((Up == DIR_UP) ? at_max : at_zero);
    assign TC   = wrap;
    assign Q    = q_q;

    // next count: load beats count, count beats hold
    always_comb begin
        q_d = L ? load_val
            : ~E ? q_q
            : (Up == DIR_UP) ? (at_max ? '0 : q_q + WIDTH'(1))
            : (at_zero ? MAX_Q : q_q - WIDTH'(1));
    end

    // count register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) q_q <= '0;
        else         q_q <= q_d;
    end

`ifdef UPDOWN_COUNT_OVF_EN
    logic ovf_q, ovf_d;

    assign Ovf = ovf_q;

    // sticky overflow: a wrap sets it even when a clear arrives on the same edge
    always_comb begin
        ovf_d = wrap | (ovf_q & ~OvfClr);
    end

    // overflow register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end
`endif
endmodule
